// File: rtl/flush_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | flush_unit: backend flush sequencer. It accepts a mispredict or an      |
// | exception, holds flush_en, then issues a fetch redirect.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module flush_unit #(
  parameter int unsigned FLUSH_HOLD_CYCLES = 2,
  parameter logic [31:0] TRAP_VECTOR       = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rob_flush_valid,
  input  logic [31:0] rob_flush_pc,
  input  logic        exc_valid,
  input  logic [31:0] exc_pc,
  output logic        flush_en,
  output logic        dispatch_stall,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  input  logic        redirect_ready,
  output logic [31:0] epc,
  output logic [15:0] flush_count
);

  localparam logic [3:0] C_HOLD_LOAD = 4'(FLUSH_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FLUSH    = 2'd1,
    REDIRECT = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  logic [31:0] epc_q, epc_d;
  logic [15:0] flush_count_q, flush_count_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= 4'd0;
      target_q      <= 32'd0;
      epc_q         <= 32'd0;
      flush_count_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      target_q      <= target_d;
      epc_q         <= epc_d;
      flush_count_q <= flush_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    target_d      = target_q;
    epc_d         = epc_q;
    flush_count_d = flush_count_q;
    unique case (state_q)
      IDLE: begin
        if (rob_flush_valid || exc_valid) begin
          state_d       = FLUSH;
          cnt_d         = C_HOLD_LOAD;
          flush_count_d = flush_count_q + 16'd1;
          // Exception takes priority over a same-cycle mispredict.
          if (exc_valid) begin
            target_d = TRAP_VECTOR;
            epc_d    = exc_pc;
          end else begin
            target_d = rob_flush_pc;
          end
        end
      end
      FLUSH: begin
        if (cnt_q == 4'd0) begin
          state_d = REDIRECT;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      REDIRECT: begin
        if (redirect_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign flush_en       = (state_q == FLUSH);
  assign redirect_valid = (state_q == REDIRECT);
  assign dispatch_stall = (state_q != IDLE);
  assign redirect_pc    = (state_q == REDIRECT) ? target_q : 32'd0;
  assign epc            = epc_q;
  assign flush_count    = flush_count_q;

endmodule
`default_nettype wire

// File: tb/tb_flush_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_flush_unit: directed and randomized checks of flush_unit against a   |
// | cycle-level reference model.                                            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_flush_unit;

  localparam int unsigned HOLD = 2;
  localparam logic [31:0] TVEC = 32'h0000_0100;

  logic        clk;
  logic        rst_n;
  logic        rob_flush_valid;
  logic [31:0] rob_flush_pc;
  logic        exc_valid;
  logic [31:0] exc_pc;
  logic        flush_en;
  logic        dispatch_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic [31:0] epc;
  logic [15:0] flush_count;

  int tests_run;
  int tests_failed;

  // Reference model: flush cycles still owed, pending redirect, captured values.
  int          m_hold_left;
  bit          m_redir;
  logic [31:0] m_target;
  logic [31:0] m_epc;
  logic [15:0] m_count;

  flush_unit #(
    .FLUSH_HOLD_CYCLES(HOLD),
    .TRAP_VECTOR(TVEC)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rob_flush_valid(rob_flush_valid),
    .rob_flush_pc(rob_flush_pc),
    .exc_valid(exc_valid),
    .exc_pc(exc_pc),
    .flush_en(flush_en),
    .dispatch_stall(dispatch_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .redirect_ready(redirect_ready),
    .epc(epc),
    .flush_count(flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_hold_left = 0;
    m_redir     = 1'b0;
    m_target    = 32'd0;
    m_epc       = 32'd0;
    m_count     = 16'd0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".flush_en"},       32'(flush_en),       32'(m_hold_left > 0));
    check({tag, ".dispatch_stall"}, 32'(dispatch_stall), 32'((m_hold_left > 0) || m_redir));
    check({tag, ".redirect_valid"}, 32'(redirect_valid), 32'(m_redir));
    check({tag, ".redirect_pc"},    redirect_pc,         m_redir ? m_target : 32'd0);
    check({tag, ".epc"},            epc,                 m_epc);
    check({tag, ".flush_count"},    32'(flush_count),    32'(m_count));
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input string tag, input bit rfv, input logic [31:0] rpc,
                      input bit ev, input logic [31:0] epc_in, input bit rdy);
    rob_flush_valid = rfv;
    rob_flush_pc    = rpc;
    exc_valid       = ev;
    exc_pc          = epc_in;
    redirect_ready  = rdy;
    if (m_hold_left == 0 && !m_redir) begin
      if (rfv || ev) begin
        m_hold_left = HOLD;
        m_target    = ev ? TVEC : rpc;
        if (ev) m_epc = epc_in;
        m_count     = m_count + 16'd1;
      end
    end else if (m_hold_left > 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_redir = 1'b1;
    end else if (rdy) begin
      m_redir = 1'b0;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic drain();
    int budget;
    budget = 0;
    while ((m_hold_left > 0 || m_redir) && budget < 50) begin
      step("drain", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
      budget++;
    end
    tests_run++;
    assert (budget < 50) else begin
      tests_failed++;
      $error("FAIL drain_timeout observed=%0d expected<50", budget);
    end
  endtask

  initial begin
    tests_run       = 0;
    tests_failed    = 0;
    rst_n           = 1'b0;
    rob_flush_valid = 1'b0;
    rob_flush_pc    = 32'd0;
    exc_valid       = 1'b0;
    exc_pc          = 32'd0;
    redirect_ready  = 1'b0;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // Mispredict, first request right after reset release, then backpressure.
    step("misp_t1", 1'b1, 32'h0000_2040, 1'b0, 32'd0, 1'b0);
    step("misp_t2", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step("misp_t3", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check("misp.redirect_pc_t3", redirect_pc, 32'h0000_2040);
    for (int i = 0; i < 4; i++) step("bp_hold", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    step("bp_handshake", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    check("bp.stall_after", 32'(dispatch_stall), 32'd0);

    // Exception and mispredict together: exception wins.
    step("simul", 1'b1, 32'h0000_4000, 1'b1, 32'h0000_3000, 1'b0);
    drain();
    check("simul.epc", epc, 32'h0000_3000);

    // Second request during FLUSH is dropped.
    step("ovl_first", 1'b1, 32'h0000_1111, 1'b0, 32'd0, 1'b0);
    step("ovl_second", 1'b1, 32'hDEAD_0000, 1'b0, 32'd0, 1'b0);
    step("ovl_wait", 1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    check("ovl.redirect_pc", redirect_pc, 32'h0000_1111);
    // Request on the handshake cycle is ignored; the next IDLE one is taken.
    step("hs_req", 1'b1, 32'h0000_5555, 1'b0, 32'd0, 1'b1);
    step("post_hs_req", 1'b1, 32'h0000_6666, 1'b0, 32'd0, 1'b0);
    drain();

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      step("rand", ($urandom % 4) == 0, $urandom, ($urandom % 8) == 0, $urandom,
           ($urandom % 2) == 1);
    end
    drain();

    // Counter wrap: preload the count, then one more accepted flush.
    @(negedge clk);
    force dut.flush_count_q = 16'hFFFF;
    #1;
    release dut.flush_count_q;
    m_count = 16'hFFFF;
    @(posedge clk);
    #1;
    check_all("wrap_preload");
    step("wrap", 1'b1, 32'h0000_7000, 1'b0, 32'd0, 1'b1);
    check("wrap.count", 32'(flush_count), 32'd0);
    drain();

    // Asynchronous reset during the second FLUSH cycle.
    step("rst_f1", 1'b1, 32'h0000_8000, 1'b1, 32'h0000_9000, 1'b1);
    step("rst_f2", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_midflush");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step("post_rst", 1'b0, 32'd0, 1'b0, 32'd0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
`default_nettype wire
